// File: rtl/rdma_tx_pkt_rx_if.sv
// Beat stream from the RDMA engine TX port plus the descriptor read port.
// The slave side is the receiver; the master side drives beats and consumes descriptors.
interface rdma_tx_pkt_rx_if #(
  parameter int LEN_W = 6
);
  logic             tx_valid;
  logic [63:0]      tx_data;
  logic             tx_last;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [7:0]       pkt_opcode;
  logic [23:0]      pkt_qpn;
  logic [23:0]      pkt_psn;
  logic [LEN_W-1:0] pkt_beats;
  logic             pkt_err;

  modport master (
    output tx_valid, tx_data, tx_last, pkt_ready,
    input  pkt_valid, pkt_opcode, pkt_qpn, pkt_psn, pkt_beats, pkt_err
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, pkt_ready,
    output pkt_valid, pkt_opcode, pkt_qpn, pkt_psn, pkt_beats, pkt_err
  );
endinterface

// File: rtl/rdma_tx_pkt_rx.sv
// Terminates the engine's outbound beat stream: delineates packets, decodes the
// header beat, checks length and queues one descriptor per packet.
module rdma_tx_pkt_rx #(
  parameter int DESC_DEPTH = 4,
  parameter int MAX_BEATS  = 32,
  parameter int LEN_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rdma_tx_pkt_rx_if.slave      bus,
  output logic [31:0]          pkt_cnt,
  output logic [15:0]          drop_cnt
);
  localparam int PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  typedef struct packed {
    logic [7:0]       opcode;
    logic [23:0]      qpn;
    logic [23:0]      psn;
    logic [LEN_W-1:0] beats;
    logic             err;
  } desc_t;

  state_t           state, state_next;
  desc_t            mem [DESC_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             reserved;

  logic [7:0]       cur_opcode;
  logic [23:0]      cur_qpn, cur_psn;
  logic [LEN_W-1:0] cur_beats, beats_inc;
  logic             cur_err, err_next;

  logic             slot_free, hdr_accept, hdr_drop, body_beat, push, pop;
  desc_t            push_desc;
  logic             unused_rsvd;

  assign unused_rsvd = ^bus.tx_data[7:0];

  // Full check looks at occupancy before any same-cycle pop, so a header racing a pop is dropped.
  assign slot_free = (32'(count) + 32'(reserved)) < DESC_DEPTH;
  assign beats_inc = (cur_beats == LEN_W'(MAX_BEATS)) ? cur_beats : cur_beats + 1'b1;
  assign err_next  = cur_err | (cur_beats == LEN_W'(MAX_BEATS));
  assign pop       = (count != '0) && bus.pkt_ready;

  always_comb begin
    state_next = state;
    hdr_accept = 1'b0;
    hdr_drop   = 1'b0;
    body_beat  = 1'b0;
    push       = 1'b0;
    push_desc  = '0;
    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          if (slot_free) begin
            hdr_accept = 1'b1;
            if (bus.tx_last) begin
              push      = 1'b1;
              push_desc = '{opcode: bus.tx_data[63:56], qpn: bus.tx_data[55:32],
                            psn: bus.tx_data[31:8], beats: LEN_W'(1), err: 1'b0};
            end else begin
              state_next = BODY;
            end
          end else begin
            hdr_drop = 1'b1;
            if (!bus.tx_last) state_next = DROP;
          end
        end
      end
      BODY: begin
        if (bus.tx_valid) begin
          body_beat = 1'b1;
          if (bus.tx_last) begin
            push       = 1'b1;
            push_desc  = '{opcode: cur_opcode, qpn: cur_qpn, psn: cur_psn,
                           beats: beats_inc, err: err_next};
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.tx_valid && bus.tx_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      reserved   <= 1'b0;
      cur_opcode <= '0;
      cur_qpn    <= '0;
      cur_psn    <= '0;
      cur_beats  <= '0;
      cur_err    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      for (int i = 0; i < DESC_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_next;
      if (hdr_accept) begin
        cur_opcode <= bus.tx_data[63:56];
        cur_qpn    <= bus.tx_data[55:32];
        cur_psn    <= bus.tx_data[31:8];
        cur_beats  <= LEN_W'(1);
        cur_err    <= 1'b0;
        reserved   <= !bus.tx_last;
      end
      if (body_beat) begin
        cur_beats <= beats_inc;
        cur_err   <= err_next;
        if (bus.tx_last) reserved <= 1'b0;
      end
      if (hdr_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      if (push) begin
        mem[wr_ptr] <= push_desc;
        wr_ptr      <= wr_ptr + 1'b1;
        pkt_cnt     <= pkt_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head entry comes straight from the storage registers, so it is stable while stalled.
  assign bus.pkt_valid  = (count != '0);
  assign bus.pkt_opcode = mem[rd_ptr].opcode;
  assign bus.pkt_qpn    = mem[rd_ptr].qpn;
  assign bus.pkt_psn    = mem[rd_ptr].psn;
  assign bus.pkt_beats  = mem[rd_ptr].beats;
  assign bus.pkt_err    = mem[rd_ptr].err;
endmodule

// File: tb/tb_rdma_tx_pkt_rx.sv
// Directed bench for rdma_tx_pkt_rx: a table of single-beat packets plus
// hand-written sequences for gaps, overlength, backpressure, full race and reset.
module tb_rdma_tx_pkt_rx;
  localparam int LEN_W = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  int          tests = 0;
  int          fails = 0;
  int          exp_pkt_cnt = 0;

  rdma_tx_pkt_rx_if #(.LEN_W(LEN_W)) bus ();

  rdma_tx_pkt_rx #(.DESC_DEPTH(4), .MAX_BEATS(32), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  opc;
    logic [23:0] qpn;
    logic [23:0] psn;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one valid beat across a single edge, then return the bus to idle.
  task automatic apply_stimulus(input logic [63:0] data, input logic last);
    bus.tx_valid = 1'b1;
    bus.tx_data  = data;
    bus.tx_last  = last;
    step();
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    bus.tx_data  = '0;
  endtask

  initial begin
    vecs[0] = '{64'h04_000011_000005_00, 8'h04, 24'h000011, 24'h000005};
    vecs[1] = '{64'h0A_ABCDEF_123456_FF, 8'h0A, 24'hABCDEF, 24'h123456};
    vecs[2] = '{64'hFF_FFFFFF_FFFFFF_00, 8'hFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{64'h00_000000_000000_7E, 8'h00, 24'h000000, 24'h000000};

    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.tx_last   = 1'b0;
    bus.pkt_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    check_output("rst_valid", 64'(bus.pkt_valid), 64'd0);
    check_output("rst_opcode", 64'(bus.pkt_opcode), 64'd0);
    check_output("rst_beats", 64'(bus.pkt_beats), 64'd0);
    check_output("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_output("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Single-beat packets from the table
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].data, 1'b1);
      exp_pkt_cnt++;
      check_output($sformatf("v%0d_valid", i), 64'(bus.pkt_valid), 64'd1);
      check_output($sformatf("v%0d_opcode", i), 64'(bus.pkt_opcode), 64'(vecs[i].opc));
      check_output($sformatf("v%0d_qpn", i), 64'(bus.pkt_qpn), 64'(vecs[i].qpn));
      check_output($sformatf("v%0d_psn", i), 64'(bus.pkt_psn), 64'(vecs[i].psn));
      check_output($sformatf("v%0d_beats", i), 64'(bus.pkt_beats), 64'd1);
      check_output($sformatf("v%0d_err", i), 64'(bus.pkt_err), 64'd0);
      check_output($sformatf("v%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(exp_pkt_cnt));
      step();
      check_output($sformatf("v%0d_popped", i), 64'(bus.pkt_valid), 64'd0);
    end

    // 4-beat packet with two idle gaps
    apply_stimulus(64'h20_000042_000099_00, 1'b0);
    check_output("gap_hdr_valid", 64'(bus.pkt_valid), 64'd0);
    step();
    apply_stimulus(64'h1111, 1'b0);
    step();
    apply_stimulus(64'h2222, 1'b0);
    check_output("gap_mid_valid", 64'(bus.pkt_valid), 64'd0);
    apply_stimulus(64'h3333, 1'b1);
    exp_pkt_cnt++;
    check_output("gap_valid", 64'(bus.pkt_valid), 64'd1);
    check_output("gap_psn", 64'(bus.pkt_psn), 64'h000099);
    check_output("gap_beats", 64'(bus.pkt_beats), 64'd4);
    check_output("gap_err", 64'(bus.pkt_err), 64'd0);
    step();

    // Overlength 35-beat packet followed by a clean 2-beat packet
    apply_stimulus(64'h0A_000100_000200_00, 1'b0);
    for (int b = 2; b <= 35; b++) apply_stimulus(64'(b), (b == 35));
    exp_pkt_cnt++;
    check_output("ovl_valid", 64'(bus.pkt_valid), 64'd1);
    check_output("ovl_opcode", 64'(bus.pkt_opcode), 64'h0A);
    check_output("ovl_beats", 64'(bus.pkt_beats), 64'd32);
    check_output("ovl_err", 64'(bus.pkt_err), 64'd1);
    apply_stimulus(64'h11_000777_000888_00, 1'b0);
    apply_stimulus(64'h5555, 1'b1);
    exp_pkt_cnt++;
    check_output("two_psn", 64'(bus.pkt_psn), 64'h000888);
    check_output("two_beats", 64'(bus.pkt_beats), 64'd2);
    check_output("two_err", 64'(bus.pkt_err), 64'd0);
    check_output("two_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
    step();

    // Backpressure: five single-beat packets into a 4-deep queue
    bus.pkt_ready = 1'b0;
    for (int p = 0; p < 5; p++) apply_stimulus({8'h01, 24'h000003, 24'(32'h10 + p), 8'h00}, 1'b1);
    exp_pkt_cnt += 4;
    check_output("bp_drop_cnt", 64'(drop_cnt), 64'd1);
    check_output("bp_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
    for (int s = 0; s < 3; s++) begin
      check_output($sformatf("bp_stall%0d_valid", s), 64'(bus.pkt_valid), 64'd1);
      check_output($sformatf("bp_stall%0d_psn", s), 64'(bus.pkt_psn), 64'h10);
      step();
    end

    // Header on the same edge as the pop that frees a slot is still dropped
    bus.pkt_ready = 1'b1;
    apply_stimulus(64'h01_000003_000020_00, 1'b1);
    bus.pkt_ready = 1'b0;
    check_output("race_drop_cnt", 64'(drop_cnt), 64'd2);
    check_output("race_head_psn", 64'(bus.pkt_psn), 64'h11);
    apply_stimulus(64'h01_000003_000021_00, 1'b1);
    exp_pkt_cnt++;
    check_output("race_after_drop_cnt", 64'(drop_cnt), 64'd2);
    check_output("race_after_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
    bus.pkt_ready = 1'b1;
    check_output("order0_psn", 64'(bus.pkt_psn), 64'h11);
    step();
    check_output("order1_psn", 64'(bus.pkt_psn), 64'h12);
    step();
    check_output("order2_psn", 64'(bus.pkt_psn), 64'h13);
    step();
    check_output("order3_psn", 64'(bus.pkt_psn), 64'h21);
    check_output("order3_valid", 64'(bus.pkt_valid), 64'd1);
    step();
    check_output("order_empty", 64'(bus.pkt_valid), 64'd0);

    // Reset during beat 3 of a 6-beat packet; the rest of that packet is abandoned
    apply_stimulus(64'h33_000aaa_000bbb_00, 1'b0);
    apply_stimulus(64'h2, 1'b0);
    rst_n = 1'b0;
    apply_stimulus(64'h3, 1'b0);
    rst_n = 1'b1;
    exp_pkt_cnt = 0;
    check_output("mid_rst_valid", 64'(bus.pkt_valid), 64'd0);
    check_output("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_output("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    step();
    check_output("mid_rst_idle_valid", 64'(bus.pkt_valid), 64'd0);
    apply_stimulus(64'h44_000ccc_000ddd_00, 1'b0);
    apply_stimulus(64'h9, 1'b1);
    exp_pkt_cnt++;
    check_output("post_rst_valid", 64'(bus.pkt_valid), 64'd1);
    check_output("post_rst_opcode", 64'(bus.pkt_opcode), 64'h44);
    check_output("post_rst_qpn", 64'(bus.pkt_qpn), 64'h000ccc);
    check_output("post_rst_psn", 64'(bus.pkt_psn), 64'h000ddd);
    check_output("post_rst_beats", 64'(bus.pkt_beats), 64'd2);
    check_output("post_rst_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
